counter_array: RTL and testbench
================================

# counter_array

Parametrised array of statistics counters held in a delayed-read `memory` instance, updated by a read-modify-write pipeline with full in-flight bypass. It extends the single-increment counter block with variable increment width, read, read-and-clear, wrap/saturate arithmetic, a ready handshake and an optional overflow indication. It sits between event sources and the host, which collects and clears statistics.

## Interface
- `NUM_COUNTERS`, 8: number of counters; `ADDR_WIDTH = $clog2(NUM_COUNTERS)`.
- `COUNTER_WIDTH`, 32: bits per counter.
- `INC_WIDTH`, 8: width of increment operand; must satisfy `INC_WIDTH <= COUNTER_WIDTH`.
- `READ_DELAY`, 3: `memory` read latency in cycles, 1 or more.
- `SATURATE`, 0: 0 = counters wrap modulo 2^COUNTER_WIDTH; 1 = counters clamp at all-ones.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_vld`  in  1  request valid.
- `req_rdy`  out  1  accept; equals `init_done`.
- `req_op`  in  2  00 INCR, 01 READ, 10 READ_CLEAR, 11 reserved (executes as READ).
- `req_addr`  in  ADDR_WIDTH  counter index.
- `req_inc`  in  INC_WIDTH  increment amount; used only by INCR.
- `rsp_vld`  out  1  response valid, one-cycle pulse.
- `rsp_addr`  out  ADDR_WIDTH  counter index of the response.
- `rsp_val`  out  COUNTER_WIDTH  post-update value for INCR; pre-op value for READ and READ_CLEAR.
- `rsp_ovf`  out  1  the INCR wrapped or clamped (see Configuration).
- `init_done`  out  1  zero-fill sweep complete.

## Operation
- **Init state.** Entered on `reset`.
  - Writes 0 to index `init_idx` = 0..NUM_COUNTERS-1, one entry per cycle.
  - Leaves init after the last index; then `init_done`=1.
  - While in init, `req_rdy`=0 and requests are not accepted.
- **Run state.** A request is accepted when `req_vld && req_rdy`; one request per cycle, no backpressure beyond init.
  - Stage 0 registers op, addr and inc, and presents `rd_en`/`rd_addr` to `memory`.
  - Stages 1..READ_DELAY carry op, addr and inc alongside the memory read.
  - At writeback (stage READ_DELAY), the old value is the bypass value on a hit, otherwise `rd_data`.
- **Writeback per op.**
  - INCR writes `old + zero-extended inc`.
  - READ_CLEAR writes 0.
  - READ performs no write.
- **Arithmetic.** The sum is computed at COUNTER_WIDTH+1 bits.
  - Carry with SATURATE=0: result is the low COUNTER_WIDTH bits.
  - Carry with SATURATE=1: result is all-ones.
  - `ovf` = carry.
- **Bypass.**
  - Writeback results, including READ_CLEAR zeros, are recorded with their address in a READ_DELAY-deep history.
  - The history also records whether each write was real; READ entries do not hit.
  - On an address match the youngest matching entry wins.
  - A write in cycle W is visible to memory reads issued at W+1 or later.
  - A read issued in the same cycle as a write returns pre-write data.
- **Out-of-range `req_addr`** (possible only when NUM_COUNTERS is not a power of 2):
  - The request is accepted and dropped: no write, no response.
  - A simulation assertion reports an error.

## Timing
- Request accepted at edge T → `rsp_vld` high in cycle T+READ_DELAY+1; memory write occurs in the same cycle.
- Throughput is one request per cycle with no bubbles, including back-to-back requests to the same address.
- Reset values:
  - `rsp_vld`, `rsp_addr`, `rsp_val`, `rsp_ovf`, `init_done`, `req_rdy` = 0.
  - All pipeline and bypass valids = 0.
- `init_done` rises NUM_COUNTERS cycles after the first cycle with `reset` low.
- Reset mid-operation:
  - All in-flight requests and bypass entries are discarded; no response is issued for them.
  - The init sweep restarts from index 0.
- Response outputs are 0 when `rsp_vld`=0.

## Configuration
- `COUNTER_ARRAY_OVF_EN` defined: `rsp_ovf` = carry of the INCR at writeback; 0 for READ and READ_CLEAR.
- Not defined: `rsp_ovf` is tied to 0 and the carry bit is not used for flagging. Saturation still follows `SATURATE`.

## Test plan
All scenarios use NUM_COUNTERS=8, COUNTER_WIDTH=8, INC_WIDTH=8, READ_DELAY=3 unless noted.
- **Init.** Deassert reset → `req_rdy`=0 for 8 cycles, then 1. READ of addr 0..7 → `rsp_val`=0 each, 4 cycles after acceptance.
- **Same-address hazard.** INCR addr 2 by 1 on 4 consecutive cycles from T → `rsp_val` 1, 2, 3, 4 in cycles T+4..T+7.
- **Wrap.** SATURATE=0, addr 3 at 250, INCR 10 → `rsp_val`=4, `rsp_ovf`=1 with macro and 0 without.
- **Saturate.** SATURATE=1, addr 3 at 250, INCR 10 → `rsp_val`=255. A further INCR 1 → 255, `rsp_ovf`=1 with macro.
- **READ_CLEAR.** Addr 5 at 7: READ_CLEAR, then INCR 1 on the next cycle → responses 7 and 1. A final READ → 1.
- **Reset mid-op.** Three INCRs in flight, reset asserted for 1 cycle → no `rsp_vld` for them. Re-init occurs, and a READ of any address returns 0.

Source files
------------

// File: rtl/counter_array.sv
// Statistics counter array: read-modify-write pipeline over a delayed-read memory with in-flight bypass.
// Define COUNTER_ARRAY_OVF_EN to drive rsp_ovf from the INCR carry; otherwise rsp_ovf is tied low.

module counter_array_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 32,
    parameter int DELAY = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0]          mem [DEPTH];
    logic [DELAY:1][W-1:0] rd_pipe;

    // The array is sampled on the edge that also commits a write, so same-cycle reads see old data.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_pipe[1] <= mem[rd_addr];
        for (int k = 2; k <= DELAY; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign rd_data = rd_pipe[DELAY];
endmodule

module counter_array #(
    parameter int  NUM_COUNTERS  = 8,
    parameter int  COUNTER_WIDTH = 32,
    parameter int  INC_WIDTH     = 8,
    parameter int  READ_DELAY    = 3,
    parameter int  SATURATE      = 0,
    localparam int ADDR_WIDTH    = $clog2(NUM_COUNTERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_vld,
    output logic                     req_rdy,
    input  logic [1:0]               req_op,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [INC_WIDTH-1:0]     req_inc,
    output logic                     rsp_vld,
    output logic [ADDR_WIDTH-1:0]    rsp_addr,
    output logic [COUNTER_WIDTH-1:0] rsp_val,
    output logic                     rsp_ovf,
    output logic                     init_done
);
    localparam int R     = READ_DELAY;
    localparam int SUM_W = COUNTER_WIDTH + 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [INC_WIDTH-1:0]  inc;
    } req_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_idx;
    logic                    in_range;
    logic [R:0]              vld_pipe;
    req_t [R:0]              req_pipe;
    req_t                    wb;
    logic [COUNTER_WIDTH-1:0] rd_data, byp_val, old_val, inc_val, wb_data, rsp_data;
    logic [SUM_W-1:0]        sum;
    logic                    byp_hit, carry, is_incr, is_clr, wb_wr;
    logic                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]   mem_wr_addr;
    logic [COUNTER_WIDTH-1:0] mem_wr_data;
    logic [R-1:0]            hist_wr;
    logic [R-1:0][ADDR_WIDTH-1:0]    hist_addr;
    logic [R-1:0][COUNTER_WIDTH-1:0] hist_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_INIT;
            init_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) init_idx <= init_idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_idx == ADDR_WIDTH'(NUM_COUNTERS - 1)) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    assign init_done = (state_q == S_RUN);
    assign req_rdy   = init_done;

    generate
        if (NUM_COUNTERS == (1 << ADDR_WIDTH)) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = (32'(req_addr) < 32'(NUM_COUNTERS));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else begin
            vld_pipe[0] <= req_vld && req_rdy && in_range;
            for (int k = 1; k <= R; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        req_pipe[0] <= '{op: req_op, addr: req_addr, inc: req_inc};
        for (int k = 1; k <= R; k++) req_pipe[k] <= req_pipe[k-1];
    end

    assign wb = req_pipe[R];

    // Youngest history entry (index 0) is visited last, so it wins on multiple hits.
    always_comb begin
        byp_hit = 1'b0;
        byp_val = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (hist_wr[i] && hist_addr[i] == wb.addr) begin
                byp_hit = 1'b1;
                byp_val = hist_val[i];
            end
        end
    end

    assign old_val  = byp_hit ? byp_val : rd_data;
    assign sum      = {1'b0, old_val} + SUM_W'(wb.inc);
    assign carry    = sum[COUNTER_WIDTH];
    assign inc_val  = (carry && SATURATE != 0) ? '1 : sum[COUNTER_WIDTH-1:0];
    assign is_incr  = (wb.op == 2'b00);
    assign is_clr   = (wb.op == 2'b10);
    assign wb_wr    = vld_pipe[R] && (is_incr || is_clr);
    assign wb_data  = is_incr ? inc_val : '0;
    assign rsp_data = is_incr ? inc_val : old_val;

    assign mem_wr_en   = !reset && (state_q == S_INIT || wb_wr);
    assign mem_wr_addr = (state_q == S_INIT) ? init_idx : wb.addr;
    assign mem_wr_data = (state_q == S_INIT) ? '0 : wb_data;

    counter_array_mem #(
        .DEPTH (NUM_COUNTERS),
        .AW    (ADDR_WIDTH),
        .W     (COUNTER_WIDTH),
        .DELAY (R)
    ) u_memory (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data),
        .rd_en   (vld_pipe[0]),
        .rd_addr (req_pipe[0].addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) hist_wr <= '0;
        else begin
            hist_wr[0] <= wb_wr;
            for (int k = 1; k < R; k++) hist_wr[k] <= hist_wr[k-1];
        end
    end

    always_ff @(posedge clk) begin
        hist_addr[0] <= wb.addr;
        hist_val[0]  <= wb_data;
        for (int k = 1; k < R; k++) begin
            hist_addr[k] <= hist_addr[k-1];
            hist_val[k]  <= hist_val[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld  <= 1'b0;
            rsp_addr <= '0;
            rsp_val  <= '0;
        end else begin
            rsp_vld  <= vld_pipe[R];
            rsp_addr <= vld_pipe[R] ? wb.addr : '0;
            rsp_val  <= vld_pipe[R] ? rsp_data : '0;
        end
    end

`ifdef COUNTER_ARRAY_OVF_EN
    always_ff @(posedge clk) begin
        if (reset) rsp_ovf <= 1'b0;
        else       rsp_ovf <= vld_pipe[R] && is_incr && carry;
    end
`else
    assign rsp_ovf = 1'b0;
`endif

    a_addr_range: assert property (@(posedge clk) disable iff (reset) (req_vld && req_rdy) |-> in_range)
        else $error("counter_array: req_addr %0d out of range", req_addr);
endmodule

// File: tb/tb_counter_array.sv
// Scoreboard bench: one wrapping and one saturating counter_array driven by identical directed requests.
module tb_counter_array;
    localparam int N  = 8;
    localparam int CW = 8;
    localparam int IW = 8;
    localparam int RD = 3;
    localparam int AW = 3;
`ifdef COUNTER_ARRAY_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_vld = 1'b0;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [IW-1:0] req_inc = '0;

    logic          rdy_w, rsp_vld_w, rsp_ovf_w, done_w;
    logic [AW-1:0] rsp_addr_w;
    logic [CW-1:0] rsp_val_w;
    logic          rdy_s, rsp_vld_s, rsp_ovf_s, done_s;
    logic [AW-1:0] rsp_addr_s;
    logic [CW-1:0] rsp_val_s;

    counter_array #(.NUM_COUNTERS(N), .COUNTER_WIDTH(CW), .INC_WIDTH(IW), .READ_DELAY(RD), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .req_vld(req_vld), .req_rdy(rdy_w), .req_op(req_op),
        .req_addr(req_addr), .req_inc(req_inc), .rsp_vld(rsp_vld_w), .rsp_addr(rsp_addr_w),
        .rsp_val(rsp_val_w), .rsp_ovf(rsp_ovf_w), .init_done(done_w));

    counter_array #(.NUM_COUNTERS(N), .COUNTER_WIDTH(CW), .INC_WIDTH(IW), .READ_DELAY(RD), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .req_vld(req_vld), .req_rdy(rdy_s), .req_op(req_op),
        .req_addr(req_addr), .req_inc(req_inc), .rsp_vld(rsp_vld_s), .rsp_addr(rsp_addr_s),
        .rsp_val(rsp_val_s), .rsp_ovf(rsp_ovf_s), .init_done(done_s));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [CW-1:0] val;
        logic          ovf;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Drives one request for one cycle; the response is due RD+1 cycles after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [IW-1:0] inc,
                         input logic [CW-1:0] vw, input logic ow, input logic [CW-1:0] vs, input logic os,
                         input bit push = 1'b1);
        exp_t e;
        req_vld  = 1'b1;
        req_op   = op;
        req_addr = addr;
        req_inc  = inc;
        if (push) begin
            e.cyc = cyc + RD + 2; e.addr = addr; e.val = vw; e.ovf = ow & OVF_EN; q_w.push_back(e);
            e.val = vs; e.ovf = os & OVF_EN; q_s.push_back(e);
        end
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_vld_w) begin
            if (q_w.size() == 0) chk("wrap unexpected rsp_vld", 32'(rsp_vld_w), 0);
            else begin
                e = q_w.pop_front();
                chk("wrap rsp cycle", 32'(cyc), 32'(e.cyc));
                chk("wrap rsp_addr", 32'(rsp_addr_w), 32'(e.addr));
                chk("wrap rsp_val", 32'(rsp_val_w), 32'(e.val));
                chk("wrap rsp_ovf", 32'(rsp_ovf_w), 32'(e.ovf));
            end
        end else chk("wrap idle outputs", 32'({rsp_addr_w, rsp_val_w, rsp_ovf_w}), 0);
        if (rsp_vld_s) begin
            if (q_s.size() == 0) chk("sat unexpected rsp_vld", 32'(rsp_vld_s), 0);
            else begin
                e = q_s.pop_front();
                chk("sat rsp cycle", 32'(cyc), 32'(e.cyc));
                chk("sat rsp_addr", 32'(rsp_addr_s), 32'(e.addr));
                chk("sat rsp_val", 32'(rsp_val_s), 32'(e.val));
                chk("sat rsp_ovf", 32'(rsp_ovf_s), 32'(e.ovf));
            end
        end else chk("sat idle outputs", 32'({rsp_addr_s, rsp_val_s, rsp_ovf_s}), 0);
    end

    task automatic init_sweep();
        for (int i = 0; i < N; i++) begin
            chk("init req_rdy low", 32'({rdy_w, rdy_s}), 0);
            @(posedge clk); #1;
        end
        chk("init_done wrap", 32'(done_w), 1);
        chk("init_done sat", 32'(done_s), 1);
        chk("req_rdy after init", 32'({rdy_w, rdy_s}), 3);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_vld", 32'({rsp_vld_w, rsp_vld_s}), 0);
        chk("reset init_done", 32'({done_w, done_s}), 0);
        chk("reset rsp_val", 32'({rsp_val_w, rsp_val_s}), 0);
        reset = 1'b0;
        init_sweep();

        for (int i = 0; i < N; i++) issue(2'b01, AW'(i), 0, 0, 0, 0, 0);

        for (int k = 1; k <= 4; k++) issue(2'b00, 2, 1, CW'(k), 0, CW'(k), 0);

        issue(2'b00, 3, 250, 250, 0, 250, 0);
        issue(2'b00, 3, 10, 4, 1, 255, 1);
        issue(2'b00, 3, 1, 5, 0, 255, 1);

        issue(2'b00, 5, 7, 7, 0, 7, 0);
        issue(2'b10, 5, 0, 7, 0, 7, 0);
        issue(2'b00, 5, 1, 1, 0, 1, 0);
        issue(2'b01, 5, 0, 1, 0, 1, 0);
        issue(2'b11, 5, 0, 1, 0, 1, 0);
        issue(2'b10, 5, 9, 1, 0, 1, 0);
        issue(2'b01, 5, 0, 0, 0, 0, 0);

        issue(2'b00, 6, 5, 5, 0, 5, 0);
        idle(1);
        issue(2'b00, 6, 5, 10, 0, 10, 0);
        idle(5);
        issue(2'b01, 6, 0, 10, 0, 10, 0);

        issue(2'b00, 0, 3, 3, 0, 3, 0);
        issue(2'b00, 1, 4, 4, 0, 4, 0);
        issue(2'b00, 0, 3, 6, 0, 6, 0);
        issue(2'b00, 1, 255, 3, 1, 255, 1);
        idle(8);

        for (int k = 0; k < 3; k++) issue(2'b00, 7, 1, 0, 0, 0, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        init_sweep();
        issue(2'b01, 7, 0, 0, 0, 0, 0);
        issue(2'b01, 3, 0, 0, 0, 0, 0);
        idle(8);

        chk("wrap queue drained", 32'(q_w.size()), 0);
        chk("sat queue drained", 32'(q_s.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
